// File: rtl/fetch_ctrl.sv
// fetch_ctrl -- instruction-fetch sequencer between the PC, the instruction
// memory and the IF/ID pipeline register.
//
// Issues one fetch at a time, waits any number of cycles for the response,
// and hands each instruction to IF/ID with its address and a valid pulse.
// Also handles load-use stalls, branch redirects (with IF/ID flush and
// discard of the in-flight response) and a terminal halt.
//
// Ports:
//   i_clk, i_rst           clock; synchronous active-high reset
//   o_i_req, o_i_addr      fetch request strobe / address (address = pc)
//   i_i_valid, i_i_inst    memory response pulse and data
//   i_stall                hold delivery (load-use hazard)
//   i_redirect(_addr)      taken branch/jump and its target
//   i_halt                 stop fetching until reset
//   o_inst, o_inst_addr    instruction and its address to IF/ID
//   o_inst_valid, o_flush  1-cycle pulses: new instruction / load a nop
//   o_done                 high while halted
//   o_fetch_cnt            saturating count of delivered instructions
//
// The block keeps no record of a fetch issued before reset, so the memory
// must be reset together with it.
module fetch_ctrl #(
  parameter int unsigned       ADDR_W   = 64,
  parameter int unsigned       INST_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  output logic              o_i_req,
  output logic [ADDR_W-1:0] o_i_addr,
  input  logic              i_i_valid,
  input  logic [INST_W-1:0] i_i_inst,
  input  logic              i_stall,
  input  logic              i_redirect,
  input  logic [ADDR_W-1:0] i_redirect_addr,
  input  logic              i_halt,
  output logic [INST_W-1:0] o_inst,
  output logic [ADDR_W-1:0] o_inst_addr,
  output logic              o_inst_valid,
  output logic              o_flush,
  output logic              o_done,
  output logic [31:0]       o_fetch_cnt
);

  typedef enum logic [2:0] {
    REQ   = 3'd0,
    WAIT  = 3'd1,
    HOLD  = 3'd2,
    DRAIN = 3'd3,
    HALT  = 3'd4
  } state_t;

  state_t              state, state_n;
  logic [ADDR_W-1:0]   pc, pc_n;
  logic [INST_W-1:0]   hold_buf, hold_buf_n;
  logic [INST_W-1:0]   inst_n;
  logic [ADDR_W-1:0]   inst_addr_n;
  logic                inst_valid_n;
  logic                flush_n;
  logic [31:0]         cnt_n;

  // A request is in flight and its response has not arrived this cycle.
  logic                outstanding;
  logic [ADDR_W-1:0]   pc_inc;
  logic [31:0]         cnt_inc;

  assign o_i_req  = (state == REQ);
  assign o_i_addr = pc;
  assign o_done   = (state == HALT);

  assign outstanding = (state == REQ) ||
                       (((state == WAIT) || (state == DRAIN)) && !i_i_valid);
  assign pc_inc      = pc + ADDR_W'(4);
  assign cnt_inc     = (o_fetch_cnt == 32'hFFFF_FFFF) ? o_fetch_cnt
                                                      : o_fetch_cnt + 32'd1;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= REQ;
      pc           <= RESET_PC;
      hold_buf     <= '0;
      o_inst       <= '0;
      o_inst_addr  <= '0;
      o_inst_valid <= 1'b0;
      o_flush      <= 1'b0;
      o_fetch_cnt  <= '0;
    end else begin
      state        <= state_n;
      pc           <= pc_n;
      hold_buf     <= hold_buf_n;
      o_inst       <= inst_n;
      o_inst_addr  <= inst_addr_n;
      o_inst_valid <= inst_valid_n;
      o_flush      <= flush_n;
      o_fetch_cnt  <= cnt_n;
    end
  end

  always_comb begin
    state_n      = state;
    pc_n         = pc;
    hold_buf_n   = hold_buf;
    inst_n       = o_inst;
    inst_addr_n  = o_inst_addr;
    inst_valid_n = 1'b0;
    flush_n      = 1'b0;
    cnt_n        = o_fetch_cnt;

    if (state != HALT && i_halt) begin
      state_n = HALT;
      flush_n = 1'b1;
    end else if (state != HALT && i_redirect) begin
      // Word-align the target; any pending response belongs to the old path
      // and must be swallowed in DRAIN before fetching the target.
      pc_n       = {i_redirect_addr[ADDR_W-1:2], 2'b00};
      flush_n    = 1'b1;
      hold_buf_n = '0;
      state_n    = outstanding ? DRAIN : REQ;
    end else begin
      unique case (state)
        REQ: state_n = WAIT;
        WAIT: begin
          if (i_i_valid) begin
            if (i_stall) begin
              hold_buf_n = i_i_inst;
              state_n    = HOLD;
            end else begin
              inst_n       = i_i_inst;
              inst_addr_n  = pc;
              inst_valid_n = 1'b1;
              pc_n         = pc_inc;
              cnt_n        = cnt_inc;
              state_n      = REQ;
            end
          end
        end
        HOLD: begin
          if (!i_stall) begin
            inst_n       = hold_buf;
            inst_addr_n  = pc;
            inst_valid_n = 1'b1;
            pc_n         = pc_inc;
            cnt_n        = cnt_inc;
            state_n      = REQ;
          end
        end
        DRAIN: if (i_i_valid) state_n = REQ;
        HALT:  state_n = HALT;
        default: state_n = REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_req;
  logic [63:0] i_addr;
  logic        i_valid = 1'b0;
  logic [31:0] i_inst = '0;
  logic        stall = 1'b0;
  logic        redir = 1'b0;
  logic [63:0] redir_addr = '0;
  logic        halt = 1'b0;
  logic [31:0] inst;
  logic [63:0] inst_addr;
  logic        inst_valid;
  logic        flush;
  logic        done;
  logic [31:0] fetch_cnt;

  int checks = 0;
  int errors = 0;

  fetch_ctrl #(.ADDR_W(64), .INST_W(32), .RESET_PC(64'h0)) dut (
    .i_clk(clk), .i_rst(rst),
    .o_i_req(i_req), .o_i_addr(i_addr),
    .i_i_valid(i_valid), .i_i_inst(i_inst),
    .i_stall(stall), .i_redirect(redir), .i_redirect_addr(redir_addr),
    .i_halt(halt),
    .o_inst(inst), .o_inst_addr(inst_addr), .o_inst_valid(inst_valid),
    .o_flush(flush), .o_done(done), .o_fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, vld;
    logic [31:0] inst;
    logic        req;
    logic [63:0] addr;
    logic        ival;
    logic [63:0] iaddr;
    logic [31:0] cnt;
  } vec_t;

  vec_t tbl[9];

  function automatic vec_t mkv(logic r, logic v, logic [31:0] in, logic q,
                               logic [63:0] a, logic iv, logic [63:0] ia,
                               logic [31:0] c);
    vec_t t;
    t.rst = r; t.vld = v; t.inst = in; t.req = q; t.addr = a;
    t.ival = iv; t.iaddr = ia; t.cnt = c;
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Apply inputs, clock once, look at the outputs just after the edge.
  task automatic step(input logic r, input logic v, input logic [31:0] in,
                      input logic s, input logic rd, input logic [63:0] ra,
                      input logic h);
    rst = r; i_valid = v; i_inst = in; stall = s; redir = rd;
    redir_addr = ra; halt = h;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(0, 0, '0, 0, 0, '0, 0);
  endtask

  task automatic outs(input string name, input logic q, input logic [63:0] a,
                      input logic iv, input logic fl, input logic dn,
                      input logic [31:0] c);
    chk({name, ".req"}, 64'(i_req), 64'(q));
    chk({name, ".addr"}, i_addr, a);
    chk({name, ".ivalid"}, 64'(inst_valid), 64'(iv));
    chk({name, ".flush"}, 64'(flush), 64'(fl));
    chk({name, ".done"}, 64'(done), 64'(dn));
    chk({name, ".cnt"}, 64'(fetch_cnt), 64'(c));
  endtask

  initial begin
    // L=1 stream of 0x13: pulses every other cycle, pc steps by 4.
    tbl[0] = mkv(1, 0, 32'h0,  1, 64'h0,  0, 64'h0, 0);
    tbl[1] = mkv(0, 0, 32'h0,  0, 64'h0,  0, 64'h0, 0);
    tbl[2] = mkv(0, 1, 32'h13, 1, 64'h4,  1, 64'h0, 1);
    tbl[3] = mkv(0, 0, 32'h0,  0, 64'h4,  0, 64'h0, 1);
    tbl[4] = mkv(0, 1, 32'h13, 1, 64'h8,  1, 64'h4, 2);
    tbl[5] = mkv(0, 0, 32'h0,  0, 64'h8,  0, 64'h4, 2);
    tbl[6] = mkv(0, 1, 32'h13, 1, 64'hC,  1, 64'h8, 3);
    tbl[7] = mkv(0, 0, 32'h0,  0, 64'hC,  0, 64'h8, 3);
    tbl[8] = mkv(0, 1, 32'h13, 1, 64'h10, 1, 64'hC, 4);

    for (int i = 0; i < 9; i++) begin
      step(tbl[i].rst, tbl[i].vld, tbl[i].inst, 0, 0, '0, 0);
      outs($sformatf("vec%0d", i), tbl[i].req, tbl[i].addr, tbl[i].ival,
           1'b0, 1'b0, tbl[i].cnt);
      if (tbl[i].ival) begin
        chk($sformatf("vec%0d.inst", i), 64'(inst), 64'(tbl[i].inst));
        chk($sformatf("vec%0d.iaddr", i), inst_addr, tbl[i].iaddr);
      end
    end

    // L=3, stall held 5 cycles across the response.
    step(1, 0, '0, 0, 0, '0, 0);
    idle();
    idle(); idle();
    outs("st.wait", 0, 64'h0, 0, 0, 0, 0);
    step(0, 1, 32'hAAAA_0001, 1, 0, '0, 0);
    outs("st.hold0", 0, 64'h0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      step(0, 0, '0, 1, 0, '0, 0);
      outs($sformatf("st.hold%0d", k + 1), 0, 64'h0, 0, 0, 0, 0);
    end
    idle();
    outs("st.rel", 1, 64'h4, 1, 0, 0, 1);
    chk("st.inst", 64'(inst), 64'hAAAA_0001);
    chk("st.iaddr", inst_addr, 64'h0);

    // Redirect in WAIT, stale response two cycles later.
    step(1, 0, '0, 0, 0, '0, 0);
    idle();
    step(0, 0, '0, 0, 1, 64'h1003, 0);
    outs("rd.flush", 0, 64'h1000, 0, 1, 0, 0);
    idle();
    outs("rd.drain", 0, 64'h1000, 0, 0, 0, 0);
    step(0, 1, 32'hDEAD_BEEF, 0, 0, '0, 0);
    outs("rd.stale", 1, 64'h1000, 0, 0, 0, 0);
    idle();
    step(0, 1, 32'h1111_2222, 0, 0, '0, 0);
    outs("rd.dlv", 1, 64'h1004, 1, 0, 0, 1);
    chk("rd.inst", 64'(inst), 64'h1111_2222);
    chk("rd.iaddr", inst_addr, 64'h1000);

    // Redirect from REQ, then another redirect while draining.
    step(1, 0, '0, 0, 0, '0, 0);
    step(0, 0, '0, 0, 1, 64'h500, 0);
    outs("dd.first", 0, 64'h500, 0, 1, 0, 0);
    step(0, 0, '0, 0, 1, 64'h602, 0);
    outs("dd.second", 0, 64'h600, 0, 1, 0, 0);
    step(0, 1, 32'h9999_9999, 0, 0, '0, 0);
    outs("dd.exit", 1, 64'h600, 0, 0, 0, 0);

    // Redirect together with the response: no drain.
    step(1, 0, '0, 0, 0, '0, 0);
    idle();
    step(0, 1, 32'h0BAD_0BAD, 0, 1, 64'h2000, 0);
    outs("rv", 1, 64'h2000, 0, 1, 0, 0);

    // Halt beats redirect; halted block ignores everything but reset.
    step(1, 0, '0, 0, 0, '0, 0);
    idle();
    step(0, 0, '0, 0, 1, 64'h3000, 1);
    outs("hl.enter", 0, 64'h0, 0, 1, 1, 0);
    step(0, 1, 32'h1234_5678, 0, 0, '0, 0);
    outs("hl.vld", 0, 64'h0, 0, 0, 1, 0);
    step(0, 0, '0, 1, 1, 64'h4000, 0);
    outs("hl.redir", 0, 64'h0, 0, 0, 1, 0);
    step(1, 0, '0, 0, 0, '0, 0);
    outs("hl.rst", 1, 64'h0, 0, 0, 0, 0);

    // PC wrap at the top of the address space, then reset mid-WAIT.
    step(1, 0, '0, 0, 0, '0, 0);
    idle();
    step(0, 1, 32'h0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0);
    outs("wr.redir", 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 1, 0, 0);
    idle();
    step(0, 1, 32'h5555_5555, 0, 0, '0, 0);
    outs("wr.dlv", 1, 64'h0, 1, 0, 0, 1);
    chk("wr.iaddr", inst_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    idle();
    step(1, 1, 32'h7777_7777, 0, 0, '0, 0);
    outs("wr.rst", 1, 64'h0, 0, 0, 0, 0);
    chk("wr.rst.inst", 64'(inst), 64'h0);
    chk("wr.rst.iaddr", inst_addr, 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
